seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter NDIGIT, default 3: number of multiplexed digits (2..8).
REQ-002 Parameter ON_CYC, default 262144: clk cycles a digit slot drives its anode; SHALL be a multiple of 8.
REQ-003 Parameter DEAD_CYC, default 1024: clk cycles all anodes are off between slots (anti-ghosting); SHALL be at least 1.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  scan enable.
REQ-007 load_valid  in  1  new display word offered.
REQ-008 load_data  in  4*NDIGIT  BCD word; digit i is load_data[4i+3:4i], digit 0 is least significant.
REQ-009 load_ready  out  1  controller can accept a word.
REQ-010 blank_lz  in  1  leading-zero suppression enable.
REQ-011 bcd_digit  out  4  BCD of the digit being scanned, driven to the external decoder.
REQ-012 digit_idx  out  $clog2(NDIGIT)  index of the current slot.
REQ-013 seg_anode  out  NDIGIT  one-hot active-high anode enables.
REQ-014 frame_done  out  1  one-cycle pulse at the end of the last slot of each frame.

Function
REQ-015 FSM states: IDLE, ON, DEAD. IDLE goes to ON (digit_idx=0) when en=1. ON goes to DEAD after ON_CYC cycles. DEAD goes to ON with digit_idx+1 after DEAD_CYC cycles, wrapping NDIGIT-1 to 0.
REQ-016 In ON, seg_anode SHALL be one-hot at bit digit_idx unless that digit is blanked by REQ-021. In IDLE and DEAD, seg_anode SHALL be all zeros.
REQ-017 bcd_digit SHALL equal active-buffer digit digit_idx, registered. It SHALL be valid from the first ON cycle and held through the DEAD state that follows.
REQ-018 frame_done SHALL pulse on the last DEAD cycle when digit_idx=NDIGIT-1.
REQ-019 Load handshake: a transfer occurs when load_valid and load_ready are both 1 on a rising edge. The word goes into a shadow register and load_ready drops to 0 on the next cycle.
REQ-020 The shadow word SHALL be copied to the active buffer on the frame_done cycle, or on any cycle in IDLE. load_ready SHALL return to 1 on the following cycle. The active buffer SHALL never change mid-frame.
REQ-021 With blank_lz=1, digit i (i>0) is blanked when every active digit from NDIGIT-1 down to i equals 0. Digit 0 SHALL never be blanked.
REQ-022 en deassertion in any state SHALL force IDLE on the next edge: anodes off, slot counters and digit_idx cleared, any pending shadow word kept.
REQ-023 If load_valid is asserted while a copy is in progress, the word SHALL NOT be accepted until load_ready=1.
REQ-024 Slot counter width SHALL be $clog2(max(ON_CYC, DEAD_CYC)). The counter SHALL never wrap within a state.

Reset
REQ-025 While rst=0, the block SHALL hold: state IDLE, seg_anode=0, bcd_digit=0, digit_idx=0, frame_done=0, load_ready=1, active and shadow buffers=0, pending flag clear.
REQ-026 Reset assertion mid-frame or mid-load SHALL take effect immediately and asynchronously, and any pending word SHALL be discarded.

Configuration
REQ-027 Macro SEVEN_SEG_DIMMING_EN: when defined, a port brightness (in, 3 bits) exists. In ON, the anode is asserted only while slot_count[MSB-:3] <= brightness, where 7 = full and 0 = 1/8 duty.
REQ-028 When SEVEN_SEG_DIMMING_EN is undefined, the brightness port is absent and the anode is asserted for the entire ON state.

Structure
REQ-029 Package seven_seg_pkg SHALL hold the FSM state encoding and the default NDIGIT, ON_CYC and DEAD_CYC constants.
REQ-030 One sub-module, scan_slot_timer, SHALL hold the loadable down-counter and produce the ON and DEAD expiry strobes.

Verification (NDIGIT=3, ON_CYC=16, DEAD_CYC=2)
REQ-031 Reset, then en=1 with active word 12'h305 -> seg_anode sequence 001, 010, 100. Each is held 16 cycles, separated by 2 cycles of 000. bcd_digit sequence 5, 0, 3. frame_done pulses once every 54 cycles.
REQ-032 Load 12'h789 in the middle of digit 1 -> load_ready=0 from the next cycle. Digits 1 and 2 still show 0 and 3. The new digits take effect at digit 0 of the next frame, and load_ready=1 one cycle after frame_done.
REQ-033 blank_lz=1, word 12'h007 -> only 001 pulses; slots 1 and 2 show 000. Word 12'h000 -> digit 0 shows 0.
REQ-034 en dropped during DEAD of digit 1 -> anodes 000 the next cycle. Re-enable -> scan restarts at digit_idx=0 with full slot length.
REQ-035 rst asserted mid-slot with a pending load -> all outputs reach reset values immediately. After release the pending word is not applied.
REQ-036 With SEVEN_SEG_DIMMING_EN and brightness=1 -> anode high for 4 of 16 ON cycles (slot_count top 3 bits 0 and 1 only).

Source files
------------

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and defaults for the seven-segment scan controller.
// Optional feature macro: SEVEN_SEG_DIMMING_EN.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_DEAD = 2'd2
  } scan_state_t;

  localparam int DEF_NDIGIT   = 3;
  localparam int DEF_ON_CYC   = 262144;
  localparam int DEF_DEAD_CYC = 1024;

  function automatic int cnt_w(input int on_cyc, input int dead_cyc);
    return $clog2(on_cyc > dead_cyc ? on_cyc : dead_cyc);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-word load handshake between a producer and the scan controller.
// Optional feature macro: SEVEN_SEG_DIMMING_EN (not used here).
interface seven_seg_scan_ctrl_if
  import seven_seg_pkg::*;
#(
  parameter int NDIGIT = DEF_NDIGIT
);
  logic                  load_valid;
  logic [4*NDIGIT-1:0]   load_data;
  logic                  load_ready;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/seven_seg_scan_ctrl_scan_slot_timer.sv
// Loadable slot down-counter producing ON and DEAD expiry strobes.
// Optional feature macro: SEVEN_SEG_DIMMING_EN exposes the count.
module scan_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int ON_CYC   = DEF_ON_CYC,
  parameter int DEAD_CYC = DEF_DEAD_CYC,
  parameter int CW       = cnt_w(ON_CYC, DEAD_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld_on,
  input  logic          ld_dead,
  input  logic          run_on,
  input  logic          run_dead,
`ifdef SEVEN_SEG_DIMMING_EN
  output logic [CW-1:0] count,
`endif
  output logic          on_exp,
  output logic          dead_exp
);

  localparam logic [CW-1:0] ON_M1   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] DEAD_M1 = CW'(DEAD_CYC - 1);

  logic [CW-1:0] cnt;
  logic          zero;

  // Saturates at zero so the count never wraps inside a state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld_on) begin
      cnt <= ON_M1;
    end else if (ld_dead) begin
      cnt <= DEAD_M1;
    end else if (!zero) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero     = (cnt == '0);
  assign on_exp   = run_on & zero;
  assign dead_exp = run_dead & zero;
`ifdef SEVEN_SEG_DIMMING_EN
  assign count    = cnt;
`endif

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered BCD word.
// Optional feature macro: SEVEN_SEG_DIMMING_EN adds a brightness port.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NDIGIT   = DEF_NDIGIT,
  parameter int ON_CYC   = DEF_ON_CYC,
  parameter int DEAD_CYC = DEF_DEAD_CYC,
  parameter int IW       = $clog2(NDIGIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef SEVEN_SEG_DIMMING_EN
  input  logic [2:0]    brightness,
`endif
  input  logic          blank_lz,
  seven_seg_scan_ctrl_if.slave ld,
  output logic [3:0]    bcd_digit,
  output logic [IW-1:0] digit_idx,
  output logic [NDIGIT-1:0] seg_anode,
  output logic          frame_done
);

  localparam int CW = cnt_w(ON_CYC, DEAD_CYC);
  localparam logic [IW-1:0] LAST = IW'(NDIGIT - 1);

  scan_state_t         state, state_nxt;
  logic [IW-1:0]       idx_nxt;
  logic [4*NDIGIT-1:0] active, shadow, act_nxt;
  logic                pending;
  logic                take, copy;
  logic                ld_on, ld_dead, clr;
  logic                on_exp, dead_exp;
  logic                dim_ok;
  logic [NDIGIT-1:0]   blank;
  logic                lead;
  logic [3:0]          dig_nxt;

  scan_slot_timer #(
    .ON_CYC   (ON_CYC),
    .DEAD_CYC (DEAD_CYC),
    .CW       (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .ld_on    (ld_on),
    .ld_dead  (ld_dead),
    .run_on   (state == ST_ON),
    .run_dead (state == ST_DEAD),
`ifdef SEVEN_SEG_DIMMING_EN
    .count    (slot_cnt),
`endif
    .on_exp   (on_exp),
    .dead_exp (dead_exp)
  );

`ifdef SEVEN_SEG_DIMMING_EN
  logic [CW-1:0] slot_cnt;
  assign dim_ok = (slot_cnt[CW-1 -: 3] <= brightness);
`else
  assign dim_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = digit_idx;
    ld_on     = 1'b0;
    ld_dead   = 1'b0;
    clr       = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      clr       = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_ON;
          idx_nxt   = '0;
          ld_on     = 1'b1;
        end
        ST_ON: if (on_exp) begin
          state_nxt = ST_DEAD;
          ld_dead   = 1'b1;
        end
        ST_DEAD: if (dead_exp) begin
          state_nxt = ST_ON;
          ld_on     = 1'b1;
          idx_nxt   = (digit_idx == LAST) ? '0 : digit_idx + IW'(1);
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign frame_done    = dead_exp & en & (digit_idx == LAST);
  assign ld.load_ready = ~pending;
  assign take          = ld.load_valid & ~pending;
  assign copy          = pending & (frame_done | (state == ST_IDLE));
  // A copy on the frame boundary must already be visible to digit 0.
  assign act_nxt       = copy ? shadow : active;
  assign dig_nxt       = act_nxt[{idx_nxt, 2'b00} +: 4];

  always_comb begin
    lead  = blank_lz;
    blank = '0;
    for (int i = NDIGIT - 1; i > 0; i--) begin
      lead     = lead & (active[4*i +: 4] == 4'd0);
      blank[i] = lead;
    end
  end

  always_comb begin
    seg_anode = '0;
    if (state == ST_ON && !blank[digit_idx] && dim_ok)
      seg_anode[digit_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      digit_idx <= '0;
      bcd_digit <= '0;
      active    <= '0;
      shadow    <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      digit_idx <= idx_nxt;
      if (ld_on)
        bcd_digit <= dig_nxt;
      if (take) begin
        shadow  <= ld.load_data;
        pending <= 1'b1;
      end else if (copy) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (NDIGIT=3, ON_CYC=16, DEAD_CYC=2).
// Optional feature macro: SEVEN_SEG_DIMMING_EN (brightness fixed at 1).
module tb_seven_seg_scan_ctrl;

  localparam int ON  = 16;
  localparam int DED = 2;

  typedef struct {
    logic [1:0]  idx;
    logic [2:0]  anode;
    logic [3:0]  bcd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       blank_lz;
  logic [2:0] brightness;
  logic [3:0] bcd_digit;
  logic [1:0] digit_idx;
  logic [2:0] seg_anode;
  logic       frame_done;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   pend  = 1'b0;
  exp_t sbq[$];

  seven_seg_scan_ctrl_if #(.NDIGIT(3)) lif ();

  seven_seg_scan_ctrl #(
    .NDIGIT   (3),
    .ON_CYC   (ON),
    .DEAD_CYC (DED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef SEVEN_SEG_DIMMING_EN
    .brightness (brightness),
`endif
    .blank_lz   (blank_lz),
    .ld         (lif),
    .bcd_digit  (bcd_digit),
    .digit_idx  (digit_idx),
    .seg_anode  (seg_anode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic push_frame(input logic [11:0] w, input bit blk);
    exp_t        e;
    logic [11:0] up;
    for (int i = 0; i < 3; i++) begin
      up    = w >> (4 * i);
      e.idx = 2'(i);
      e.bcd = up[3:0];
      if (blk && i > 0 && up == 12'h000) e.anode = 3'b000;
      else                               e.anode = 3'b001 << i;
      sbq.push_back(e);
    end
  endtask

  task automatic load_word(input logic [11:0] w);
    int k = 0;
    while (lif.load_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k == 20) begin
      n_bad++;
      $display("FAIL load_wait: ready stuck at %b, need 1", lif.load_ready);
    end
    lif.load_valid = 1'b1;
    lif.load_data  = w;
    @(negedge clk);
    lif.load_valid = 1'b0;
    n_cmp++;
    if (lif.load_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL load_busy: ready %b, need 0", lif.load_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (lif.load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL load_idle_copy: ready %b, need 1", lif.load_ready);
    end
  endtask

  // Walks slot timing cycle by cycle, popping one expectation per slot.
  task automatic run_frames(input int nslots, input int load_slot,
                            input logic [11:0] lword, input int drop_slot);
    exp_t       e;
    logic [2:0] exp_an;
    bit         fd;
    for (int s = 0; s < nslots; s++) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty: slot %0d has no expectation", s);
        return;
      end
      e = sbq.pop_front();
      for (int c = 0; c < ON; c++) begin
        @(negedge clk);
        if (lif.load_valid) begin
          lif.load_valid = 1'b0;
          pend = 1'b1;
        end
        exp_an = e.anode;
`ifdef SEVEN_SEG_DIMMING_EN
        if (c < ON - 4) exp_an = 3'b000;
`endif
        n_cmp++;
        if (seg_anode !== exp_an) begin
          n_bad++;
          $display("FAIL on_anode s%0d c%0d: got %b need %b", s, c, seg_anode, exp_an);
        end
        n_cmp++;
        if (bcd_digit !== e.bcd) begin
          n_bad++;
          $display("FAIL on_bcd s%0d c%0d: got %h need %h", s, c, bcd_digit, e.bcd);
        end
        n_cmp++;
        if (digit_idx !== e.idx) begin
          n_bad++;
          $display("FAIL on_idx s%0d c%0d: got %0d need %0d", s, c, digit_idx, e.idx);
        end
        n_cmp++;
        if (frame_done !== 1'b0) begin
          n_bad++;
          $display("FAIL on_fd s%0d c%0d: got %b need 0", s, c, frame_done);
        end
        n_cmp++;
        if (lif.load_ready !== !pend) begin
          n_bad++;
          $display("FAIL on_ready s%0d c%0d: got %b need %b", s, c, lif.load_ready, !pend);
        end
        if (s == load_slot && c == 5) begin
          lif.load_valid = 1'b1;
          lif.load_data  = lword;
        end
      end
      for (int d = 0; d < DED; d++) begin
        @(negedge clk);
        fd = (d == DED - 1) && (e.idx == 2'd2);
        n_cmp++;
        if (seg_anode !== 3'b000) begin
          n_bad++;
          $display("FAIL dead_anode s%0d d%0d: got %b need 000", s, d, seg_anode);
        end
        n_cmp++;
        if (bcd_digit !== e.bcd) begin
          n_bad++;
          $display("FAIL dead_bcd s%0d d%0d: got %h need %h", s, d, bcd_digit, e.bcd);
        end
        n_cmp++;
        if (frame_done !== fd) begin
          n_bad++;
          $display("FAIL dead_fd s%0d d%0d: got %b need %b", s, d, frame_done, fd);
        end
        n_cmp++;
        if (lif.load_ready !== !pend) begin
          n_bad++;
          $display("FAIL dead_ready s%0d d%0d: got %b need %b", s, d, lif.load_ready, !pend);
        end
        if (fd) pend = 1'b0;
        if (s == drop_slot && d == 0) begin
          en = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seg_anode !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_anode: got %b need 000", seg_anode);
    end
    n_cmp++;
    if (bcd_digit !== 4'h0) begin
      n_bad++;
      $display("FAIL rst_bcd: got %h need 0", bcd_digit);
    end
    n_cmp++;
    if (digit_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_idx: got %0d need 0", digit_idx);
    end
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_fd: got %b need 0", frame_done);
    end
    n_cmp++;
    if (lif.load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready: got %b need 1", lif.load_ready);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan;
    load_word(12'h305);
    push_frame(12'h305, 1'b0);
    push_frame(12'h305, 1'b0);
    @(negedge clk);
    en = 1'b1;
    run_frames(6, -1, 12'h000, -1);
  endtask

  task automatic test_midload;
    push_frame(12'h305, 1'b0);
    push_frame(12'h789, 1'b0);
    run_frames(6, 1, 12'h789, -1);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_blank;
    blank_lz = 1'b1;
    load_word(12'h007);
    push_frame(12'h007, 1'b1);
    en = 1'b1;
    run_frames(3, -1, 12'h000, -1);
    en = 1'b0;
    @(negedge clk);
    load_word(12'h000);
    push_frame(12'h000, 1'b1);
    en = 1'b1;
    run_frames(3, -1, 12'h000, -1);
    en = 1'b0;
    blank_lz = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_en_drop;
    load_word(12'h305);
    push_frame(12'h305, 1'b0);
    en = 1'b1;
    run_frames(3, -1, 12'h000, 1);
    sbq.delete();
    @(negedge clk);
    n_cmp++;
    if (seg_anode !== 3'b000) begin
      n_bad++;
      $display("FAIL drop_anode: got %b need 000", seg_anode);
    end
    n_cmp++;
    if (digit_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL drop_idx: got %0d need 0", digit_idx);
    end
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_fd: got %b need 0", frame_done);
    end
    en = 1'b1;
    push_frame(12'h305, 1'b0);
    run_frames(3, -1, 12'h000, -1);
  endtask

  task automatic test_reset_mid;
    push_frame(12'h305, 1'b0);
    run_frames(1, -1, 12'h000, -1);
    repeat (5) @(negedge clk);
    lif.load_valid = 1'b1;
    lif.load_data  = 12'h789;
    @(negedge clk);
    lif.load_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (seg_anode !== 3'b000) begin
      n_bad++;
      $display("FAIL arst_anode: got %b need 000", seg_anode);
    end
    n_cmp++;
    if (bcd_digit !== 4'h0) begin
      n_bad++;
      $display("FAIL arst_bcd: got %h need 0", bcd_digit);
    end
    n_cmp++;
    if (digit_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL arst_idx: got %0d need 0", digit_idx);
    end
    n_cmp++;
    if (lif.load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_ready: got %b need 1", lif.load_ready);
    end
    sbq.delete();
    pend = 1'b0;
    en   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    en = 1'b1;
    push_frame(12'h000, 1'b0);
    run_frames(3, -1, 12'h000, -1);
    en = 1'b0;
  endtask

  initial begin
    en             = 1'b0;
    blank_lz       = 1'b0;
    brightness     = 3'd1;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    test_reset();
    test_scan();
    test_midload();
    test_blank();
    test_en_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
